// File: rtl/param_updown_counter_if.sv
// ---------------------------------------------------------------------------
// param_updown_counter_if
//
// Bundles the control and status signals of one param_updown_counter stage.
//
// Parameter:
//   WIDTH     counter width in bits; must match the attached counter's WIDTH
//
// Signals:
//   en        count enable (one step per cycle while high)
//   up        direction, 1 = increment, 0 = decrement
//   load      parallel load strobe
//   load_val  value to load (clamped to MOD-1 by the counter)
//   count     registered current count
//   tc        combinational terminal count, feeds en of the next stage
//   wrap      registered one-cycle pulse after a bound-crossing update
//   zero      registered flag, high while count == 0
//
// Modports:
//   master    drives the controls and observes the status (user side)
//   slave     the counter itself
// ---------------------------------------------------------------------------
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             zero;

  modport master (
    output en, up, load, load_val,
    input  count, tc, wrap, zero
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, wrap, zero
  );
endinterface

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised synchronous up/down counter with modulus, parallel load and
// cascade outputs. Count range is 0..MOD-1.
//
// The counter width may be 2..32 bits; the modulus may be 2..2**WIDTH, and
// elaboration stops with an error outside those ranges.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    param_updown_counter_if.slave: en, up, load, load_val in;
//          count, tc, wrap, zero out
//
// Priority per edge: reset > load > en > hold.
//
// Compile-time option:
//   COUNTER_SATURATE_EN  when defined the counter holds at the bounds instead
//                        of wrapping, and wrap is tied low. tc still asserts
//                        at the bound so saturation is visible outside.
// ---------------------------------------------------------------------------
module param_updown_counter #(
  parameter int              WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input logic                   clk,
  input logic                   reset,
  param_updown_counter_if.slave bus
);

  // Parameter legality is checked at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 2..32");
  end
  if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("param_updown_counter: MOD must be in 2..2**WIDTH");
  end

  // Arithmetic is done one bit wider than the count so that MOD == 2**WIDTH
  // never relies on natural binary overflow.
  localparam logic [WIDTH:0] MOD_MAX = (WIDTH+1)'(MOD - 64'd1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             zero_reg;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   load_ext;
  logic             inc_over;   // count sits at MOD-1
  logic             dec_under;  // count sits at 0
  logic             load_clamp;

  assign count_ext  = {1'b0, count_reg};
  assign inc_ext    = count_ext + ONE_EXT;
  assign dec_ext    = count_ext - ONE_EXT;
  assign load_ext   = {1'b0, bus.load_val};

  // An increment past MOD-1 or a borrow out of 0 marks the bound.
  assign inc_over   = (inc_ext > MOD_MAX);
  assign dec_under  = dec_ext[WIDTH];
  assign load_clamp = (load_ext > MOD_MAX);

  // Terminal count is purely combinational so a cascaded stage steps on the
  // same edge as this stage's bound crossing.
  assign bus.tc = bus.en & (bus.up ? inc_over : dec_under);

`ifdef COUNTER_SATURATE_EN

  // Saturating variant: bounds hold the count, wrap never fires.
  always_comb begin
    count_next = count_reg;
    if (bus.load) begin
      count_next = load_clamp ? MOD_MAX[WIDTH-1:0] : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (!inc_over) begin
          count_next = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (!dec_under) begin
          count_next = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      zero_reg  <= 1'b1;
    end else begin
      count_reg <= count_next;
      zero_reg  <= (count_next == '0);
    end
  end

  assign bus.wrap = 1'b0;

`else

  logic wrap_reg;
  logic wrap_next;

  // Wrapping variant: crossing a bound jumps to the opposite bound and
  // raises wrap for exactly the following cycle.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (bus.load) begin
      count_next = load_clamp ? MOD_MAX[WIDTH-1:0] : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (inc_over) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (dec_under) begin
          count_next = MOD_MAX[WIDTH-1:0];
          wrap_next  = 1'b1;
        end else begin
          count_next = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      zero_reg  <= 1'b1;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      zero_reg  <= (count_next == '0);
    end
  end

  assign bus.wrap = wrap_reg;

`endif

  assign bus.count = count_reg;
  assign bus.zero  = zero_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_param_updown_counter
//
// Three stages: lo (MOD=10) driven directly, hi (MOD=10) cascaded from lo.tc,
// and full (MOD=16 = 2**WIDTH) sharing lo's controls. Each stimulus cycle
// pushes its hand-computed expectations into a queue; a monitor pops one
// entry per cycle, checks tc before the edge and count/wrap/zero after it.
// ---------------------------------------------------------------------------
module tb_param_updown_counter;

  logic clk;
  logic reset;

  param_updown_counter_if #(.WIDTH(4)) lo_if ();
  param_updown_counter_if #(.WIDTH(4)) hi_if ();
  param_updown_counter_if #(.WIDTH(4)) f_if ();

  param_updown_counter #(.WIDTH(4), .MOD(10)) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (lo_if)
  );

  param_updown_counter #(.WIDTH(4), .MOD(10)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (hi_if)
  );

  param_updown_counter #(.WIDTH(4), .MOD(16)) dut_f (
    .clk   (clk),
    .reset (reset),
    .bus   (f_if)
  );

  assign hi_if.en       = lo_if.tc;
  assign hi_if.up       = 1'b1;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = 4'd0;

  assign f_if.en        = lo_if.en;
  assign f_if.up        = lo_if.up;
  assign f_if.load      = lo_if.load;
  assign f_if.load_val  = lo_if.load_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int c;    // lo count after the edge
    bit w;    // lo wrap after the edge
    bit z;    // lo zero after the edge
    bit t;    // lo tc before the edge
    int hc;   // hi count after the edge, -1 = unchecked
    int fc;   // full count after the edge, -1 = unchecked
    bit fw;   // full wrap after the edge (checked with fc)
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (txn %0d)", nm, act, req, txn);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, record expectations.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv,
                      input int c, input bit w, input bit z, input bit t,
                      input int hc, input int fc, input bit fw);
    exp_t x;
    int   lvv;
    @(negedge clk);
    lvv            = lv;
    reset          = r;
    lo_if.en       = e;
    lo_if.up       = u;
    lo_if.load     = l;
    lo_if.load_val = lvv[3:0];
    x.c  = c;
    x.w  = w;
    x.z  = z;
    x.t  = t;
    x.hc = hc;
    x.fc = fc;
    x.fw = fw;
    exp_q.push_back(x);
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tc", {31'd0, lo_if.tc}, {31'd0, e.t});
        @(posedge clk);
        #1;
        chk("count", {28'd0, lo_if.count}, e.c);
        chk("wrap",  {31'd0, lo_if.wrap},  {31'd0, e.w});
        chk("zero",  {31'd0, lo_if.zero},  {31'd0, e.z});
        if (e.hc >= 0) chk("hi_count", {28'd0, hi_if.count}, e.hc);
        if (e.fc >= 0) begin
          chk("full_count", {28'd0, f_if.count}, e.fc);
          chk("full_wrap",  {31'd0, f_if.wrap},  {31'd0, e.fw});
        end
        $display("txn %0d: count=%0d wrap=%0b zero=%0b tc=%0b hi=%0d full=%0d",
                 txn, lo_if.count, lo_if.wrap, lo_if.zero, e.t, hi_if.count, f_if.count);
        txn++;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    lo_if.en       = 1'b0;
    lo_if.up       = 1'b0;
    lo_if.load     = 1'b0;
    lo_if.load_val = 4'd0;

    // Reset state.
    step(1, 0, 0, 0, 0,   0, 0, 1, 0,   0, 0, 0);

`ifndef COUNTER_SATURATE_EN
    // Count up 12 from reset: 1..9, 0 (wrap), 1, 2.
    for (int k = 1; k <= 12; k++)
      step(0, 1, 1, 0, 0, k % 10, k == 10, k == 10, k == 10, -1, k, 0);

    // Count down 3 from reset: 9 (wrap), 8, 7; then hold.
    step(1, 0, 0, 0, 0,   0, 0, 1, 0,  -1,  0, 0);
    step(0, 1, 0, 0, 0,   9, 1, 0, 1,  -1, 15, 1);
    step(0, 1, 0, 0, 0,   8, 0, 0, 0,  -1, 14, 0);
    step(0, 1, 0, 0, 0,   7, 0, 0, 0,  -1, 13, 0);
    step(0, 0, 0, 0, 0,   7, 0, 0, 0,  -1, 13, 0);
`endif

    // Load clamp and priority.
    step(1, 0, 0, 0, 0,   0, 0, 1, 0,  -1,  0, 0);
    step(0, 1, 1, 1, 13,  9, 0, 0, 0,  -1, 13, 0);  // clamp to 9, en ignored
    step(1, 1, 1, 1, 4,   0, 0, 1, 1,  -1,  0, 0);  // reset beats load
    step(0, 1, 0, 1, 5,   5, 0, 0, 1,  -1,  5, 0);  // load beats down-wrap
    step(0, 0, 1, 1, 15,  9, 0, 0, 0,  -1, 15, 0);  // lo clamps, full takes 15
`ifdef COUNTER_SATURATE_EN
    step(0, 1, 1, 0, 0,   9, 0, 0, 1,  -1, 15, 0);
    step(0, 1, 0, 0, 0,   8, 0, 0, 0,  -1, 14, 0);
`else
    step(0, 1, 1, 0, 0,   0, 1, 1, 1,  -1,  0, 1);  // both wrap at the top
    step(0, 1, 0, 0, 0,   9, 1, 0, 1,  -1, 15, 1);  // direction toggle at bound
`endif

    // Mid-run reset with en high, then resume.
    step(1, 0, 0, 0, 0,   0, 0, 1, 0,  -1,  0, 0);
    for (int k = 1; k <= 6; k++)
      step(0, 1, 1, 0, 0, k, 0, 0, 0, -1, k, 0);
    step(1, 1, 1, 0, 0,   0, 0, 1, 0,  -1,  0, 0);
    step(0, 1, 1, 0, 0,   1, 0, 0, 0,  -1,  1, 0);

`ifdef COUNTER_SATURATE_EN
    // Saturation: 15 up-steps hold at 9, then 12 down-steps hold at 0.
    step(1, 0, 0, 0, 0,   0, 0, 1, 0,  -1,  0, 0);
    for (int k = 1; k <= 15; k++)
      step(0, 1, 1, 0, 0, (k < 9) ? k : 9, 0, 0, k >= 10, -1, k, 0);
    for (int j = 1; j <= 12; j++)
      step(0, 1, 0, 0, 0, (j < 9) ? 9 - j : 0, 0, j >= 9, j >= 10, -1, 15 - j, 0);
`else
    // Cascade: 25 enabled cycles -> hi=2, lo=5.
    step(1, 0, 0, 0, 0,   0, 0, 1, 0,   0,  0, 0);
    for (int k = 1; k <= 25; k++)
      step(0, 1, 1, 0, 0, k % 10, (k % 10) == 0, (k % 10) == 0, (k % 10) == 0,
           k / 10, k % 16, k == 16);
`endif

    @(negedge clk);
    lo_if.en   = 1'b0;
    lo_if.load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
